prime_bitmap_reader: RTL

Read-side companion to the sieve engine. It waits for the sieve-complete flag, then scans the 1-bit primality bitmap RAM through its read port. Each prime found is presented on a valid/ready output, one prime per handshake. Downstream consumers (BCD converter and 7-segment display, paced by the one-second tick) pull primes in ascending order.

---
 rtl/prime_reader_pkg.sv | 14 +
 rtl/prime_bitmap_reader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/prime_reader_pkg.sv
// Shared types for the prime bitmap reader: scan FSM states and first candidate.
package prime_reader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOK,
      CHECK,
      HOLD,
      DONE
   } state_t;

   localparam int unsigned FIRST_CAND = 2;

endpackage

// File: rtl/prime_bitmap_reader.sv
// Scans the primality bitmap after sieve completion and streams primes on valid/ready; 2 cycles per
// candidate, prime_o held while prime_ready is low. PRIME_READER_WRAP_EN: rescan forever, done pulses.
module prime_bitmap_reader
   import prime_reader_pkg::*;
#(
   parameter int unsigned N  = 1000000,
   parameter int unsigned AW = 20
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   output logic [AW-1:0] rd_addr,
   input  logic          rd_data,
   output logic [AW-1:0] prime_o,
   output logic          prime_valid,
   input  logic          prime_ready,
   output logic [AW-1:0] count_o,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] FIRST     = AW'(FIRST_CAND);
   localparam logic [AW-1:0] LAST_CAND = AW'(N - 1);
   localparam logic [AW-1:0] ONE       = AW'(1);

   state_t        r_state;
   logic [AW-1:0] r_cand;
   logic [AW-1:0] r_rd_addr;
   logic [AW-1:0] r_prime;
   logic          r_valid;
   logic [AW-1:0] r_count;
   logic          r_done;

   state_t        w_state;
   logic [AW-1:0] w_cand;
   logic [AW-1:0] w_rd_addr;
   logic [AW-1:0] w_prime;
   logic          w_valid;
   logic [AW-1:0] w_count;
   logic          w_done;
   logic          w_advance;
   logic          w_last;

   assign w_last = (r_cand == LAST_CAND);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_cand    <= '0;
         r_rd_addr <= '0;
         r_prime   <= '0;
         r_valid   <= 1'b0;
         r_count   <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cand    <= w_cand;
         r_rd_addr <= w_rd_addr;
         r_prime   <= w_prime;
         r_valid   <= w_valid;
         r_count   <= w_count;
         r_done    <= w_done;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_cand    = r_cand;
      w_rd_addr = r_rd_addr;
      w_prime   = r_prime;
      w_valid   = r_valid;
      w_count   = r_count;
`ifdef PRIME_READER_WRAP_EN
      w_done    = 1'b0;
`else
      w_done    = r_done;
`endif
      w_advance = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_cand    = FIRST;
               w_rd_addr = FIRST;
               w_state   = LOOK;
            end
         end
         // RAM captures rd_addr on this edge; its data is ready for CHECK.
         LOOK: w_state = CHECK;
         CHECK: begin
            if (rd_data) begin
               w_prime = r_cand;
               w_valid = 1'b1;
               w_state = HOLD;
            end else begin
               w_advance = 1'b1;
            end
         end
         HOLD: begin
            if (r_valid && prime_ready) begin
               w_valid   = 1'b0;
               w_count   = r_count + ONE;
               w_advance = 1'b1;
            end
         end
         DONE: begin
            w_valid = 1'b0;
            w_done  = 1'b1;
         end
         default: w_state = IDLE;
      endcase

      // Leaving a candidate: either step to the next one or finish the scan.
      if (w_advance) begin
         if (w_last) begin
`ifdef PRIME_READER_WRAP_EN
            w_cand    = FIRST;
            w_rd_addr = FIRST;
            w_count   = '0;
            w_done    = 1'b1;
            w_state   = LOOK;
`else
            w_done    = 1'b1;
            w_state   = DONE;
`endif
         end else begin
            w_cand    = r_cand + ONE;
            w_rd_addr = r_cand + ONE;
            w_state   = LOOK;
         end
      end
   end

   assign rd_addr     = r_rd_addr;
   assign prime_o     = r_prime;
   assign prime_valid = r_valid;
   assign count_o     = r_count;
   assign done        = r_done;
   assign busy        = (r_state == LOOK) || (r_state == CHECK) || (r_state == HOLD);

endmodule
